// File: rtl/mem_dbus_stage_pkg.sv
// Shared definitions for the MiniMIPS32 memory-access stage: aluop codes,
// exception codes, data-bus size encodings, FSM states and op decoding.
package mem_dbus_stage_pkg;

  localparam logic [7:0] ALUOP_LB  = 8'h90;
  localparam logic [7:0] ALUOP_LBU = 8'h91;
  localparam logic [7:0] ALUOP_LH  = 8'h92;
  localparam logic [7:0] ALUOP_LHU = 8'h93;
  localparam logic [7:0] ALUOP_LW  = 8'h94;
  localparam logic [7:0] ALUOP_SB  = 8'h98;
  localparam logic [7:0] ALUOP_SH  = 8'h99;
  localparam logic [7:0] ALUOP_SW  = 8'h9A;

  localparam logic [4:0] EXC_NONE = 5'h10;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;

  typedef logic [1:0] dsize_t;
  localparam dsize_t SIZE_BYTE = 2'd0;
  localparam dsize_t SIZE_HALF = 2'd1;
  localparam dsize_t SIZE_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } dbus_state_e;

  typedef struct packed {
    logic   is_load;
    logic   is_store;
    logic   is_unsigned;
    dsize_t size;
  } op_dec_t;

  function automatic op_dec_t decode_aluop(input logic [7:0] op);
    op_dec_t d;
    d = '0;
    case (op)
      ALUOP_LB, ALUOP_LBU: begin
        d.is_load     = 1'b1;
        d.is_unsigned = (op == ALUOP_LBU);
        d.size        = SIZE_BYTE;
      end
      ALUOP_LH, ALUOP_LHU: begin
        d.is_load     = 1'b1;
        d.is_unsigned = (op == ALUOP_LHU);
        d.size        = SIZE_HALF;
      end
      ALUOP_LW: begin
        d.is_load = 1'b1;
        d.size    = SIZE_WORD;
      end
      ALUOP_SB: begin
        d.is_store = 1'b1;
        d.size     = SIZE_BYTE;
      end
      ALUOP_SH: begin
        d.is_store = 1'b1;
        d.size     = SIZE_HALF;
      end
      ALUOP_SW: begin
        d.is_store = 1'b1;
        d.size     = SIZE_WORD;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic addr_misaligned(input dsize_t size, input logic [1:0] lo);
    case (size)
      SIZE_HALF: return lo[0];
      SIZE_WORD: return (lo != 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

  // Replicate the store value across every lane so the slave can pick by address.
  function automatic logic [31:0] store_lanes(input dsize_t size, input logic [31:0] din);
    case (size)
      SIZE_BYTE: return {4{din[7:0]}};
      SIZE_HALF: return {2{din[15:0]}};
      default:   return din;
    endcase
  endfunction

endpackage

// File: rtl/mem_dbus_stage_if.sv
// SRAM-like data bus between the memory-access stage (master) and the
// data memory / bridge (slave).
interface mem_dbus_stage_if
  import mem_dbus_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();

  logic              data_req;
  logic              data_wr;
  dsize_t            data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/mem_dbus_stage_load_align_ext.sv
// Selects the addressed byte/half of a loaded word and sign- or zero-extends it.
module load_align_ext
  import mem_dbus_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_addr_lo,
  input  dsize_t            i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_data
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  always_comb begin
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];

    case (i_size)
      SIZE_BYTE: o_data = i_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}
                                     : {{(DATA_W-8){w_byte[7]}}, w_byte};
      SIZE_HALF: o_data = i_unsigned ? {{(DATA_W-16){1'b0}}, w_half}
                                     : {{(DATA_W-16){w_half[15]}}, w_half};
      default:   o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_dbus_stage.sv
// MiniMIPS32 memory-access stage: runs loads/stores over the SRAM-like data bus,
// checks alignment, and feeds the MEM/WB register.
module mem_dbus_stage
  import mem_dbus_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst,
  input  logic [7:0]  mem_aluop,
  input  logic [4:0]  mem_wa,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wd,
  input  logic        mem_mreg,
  input  logic [31:0] mem_din,
  input  logic [4:0]  mem_exccode,
  input  logic        flush,
  input  logic        stall_hold,
  mem_dbus_stage_if.master dbus,
  output logic        stallreq_mem,
  output logic [4:0]  wb_wa,
  output logic        wb_wreg,
  output logic [31:0] wb_wd,
  output logic [4:0]  wb_exccode,
  output logic [31:0] wb_badvaddr
);

  op_dec_t           w_dec;
  logic              w_memop;
  logic              w_misalign;
  logic              w_access;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_load_data;
  logic              w_in_req;

  dbus_state_e       r_state;
  logic [DATA_W-1:0] r_rdata_q;
  logic              r_flush_seen;
  logic [ADDR_W-1:0] r_req_addr;
  dsize_t            r_req_size;
  logic [DATA_W-1:0] r_req_wdata;
  logic              r_req_wr;

  always_comb begin
    w_dec      = decode_aluop(mem_aluop);
    w_memop    = w_dec.is_load | w_dec.is_store;
    w_misalign = w_memop & addr_misaligned(w_dec.size, mem_wd[1:0]);
    w_access   = w_memop & (mem_exccode == EXC_NONE) & ~w_misalign & ~flush;
    w_wdata    = store_lanes(w_dec.size, mem_din);
    w_in_req   = (r_state == ST_REQ);
  end

  load_align_ext #(
    .DATA_W(DATA_W)
  ) u_load_align_ext (
    .i_word    (r_rdata_q),
    .i_addr_lo (mem_wd[1:0]),
    .i_size    (w_dec.size),
    .i_unsigned(w_dec.is_unsigned),
    .o_data    (w_load_data)
  );

  // Request fields are captured at issue so a flush that clears EXE/MEM
  // cannot disturb a request the slave has not yet accepted.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state      <= ST_IDLE;
      r_rdata_q    <= '0;
      r_flush_seen <= 1'b0;
      r_req_addr   <= '0;
      r_req_size   <= SIZE_BYTE;
      r_req_wdata  <= '0;
      r_req_wr     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_req_addr   <= mem_wd[ADDR_W-1:0];
            r_req_size   <= w_dec.size;
            r_req_wdata  <= w_wdata;
            r_req_wr     <= w_dec.is_store;
            r_flush_seen <= 1'b0;
            r_state      <= dbus.data_addr_ok ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          if (dbus.data_addr_ok) begin
            r_state      <= (r_flush_seen | flush) ? ST_DRAIN : ST_WAIT;
            r_flush_seen <= 1'b0;
          end else if (flush) begin
            r_flush_seen <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (dbus.data_data_ok) begin
            if (flush) begin
              r_state <= ST_IDLE;
            end else begin
              r_state   <= ST_DONE;
              r_rdata_q <= dbus.data_rdata;
            end
          end else if (flush) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          if (!stall_hold || flush) r_state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (dbus.data_data_ok) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are forced to their idle values while reset is held.
  always_comb begin
    dbus.data_req   = 1'b0;
    dbus.data_wr    = 1'b0;
    dbus.data_size  = SIZE_BYTE;
    dbus.data_addr  = '0;
    dbus.data_wdata = '0;
    stallreq_mem    = 1'b0;
    wb_wa           = '0;
    wb_wreg         = 1'b0;
    wb_wd           = '0;
    wb_exccode      = EXC_NONE;
    wb_badvaddr     = '0;
    if (!cpu_rst) begin
      dbus.data_req   = ((r_state == ST_IDLE) & w_access) | w_in_req;
      dbus.data_wr    = w_in_req ? r_req_wr    : w_dec.is_store;
      dbus.data_size  = w_in_req ? r_req_size  : w_dec.size;
      dbus.data_addr  = w_in_req ? r_req_addr  : mem_wd[ADDR_W-1:0];
      dbus.data_wdata = w_in_req ? r_req_wdata : w_wdata;

      stallreq_mem = ((r_state == ST_IDLE) & w_access) | w_in_req |
                     (r_state == ST_WAIT) | ((r_state == ST_DRAIN) & w_access);

      wb_wa       = mem_wa;
      wb_wreg     = mem_wreg & ~w_misalign & ~flush;
      wb_wd       = mem_mreg ? w_load_data : mem_wd;
      wb_exccode  = w_misalign ? (w_dec.is_load ? EXC_ADEL : EXC_ADES) : mem_exccode;
      wb_badvaddr = w_misalign ? mem_wd : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_dbus_stage.sv
// Self-checking bench for mem_dbus_stage with a delay-programmable bus slave
// and a scoreboard of expected write-back results.
module tb_mem_dbus_stage;
  import mem_dbus_stage_pkg::*;

  logic        cpu_clk_50M = 1'b0;
  logic        cpu_rst;
  logic [7:0]  mem_aluop;
  logic [4:0]  mem_wa;
  logic        mem_wreg;
  logic [31:0] mem_wd;
  logic        mem_mreg;
  logic [31:0] mem_din;
  logic [4:0]  mem_exccode;
  logic        flush;
  logic        stall_hold;
  logic        stallreq_mem;
  logic [4:0]  wb_wa;
  logic        wb_wreg;
  logic [31:0] wb_wd;
  logic [4:0]  wb_exccode;
  logic [31:0] wb_badvaddr;

  always #5 cpu_clk_50M = ~cpu_clk_50M;

  mem_dbus_stage_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

  mem_dbus_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .cpu_clk_50M (cpu_clk_50M),
    .cpu_rst     (cpu_rst),
    .mem_aluop   (mem_aluop),
    .mem_wa      (mem_wa),
    .mem_wreg    (mem_wreg),
    .mem_wd      (mem_wd),
    .mem_mreg    (mem_mreg),
    .mem_din     (mem_din),
    .mem_exccode (mem_exccode),
    .flush       (flush),
    .stall_hold  (stall_hold),
    .dbus        (dbus),
    .stallreq_mem(stallreq_mem),
    .wb_wa       (wb_wa),
    .wb_wreg     (wb_wreg),
    .wb_wd       (wb_wd),
    .wb_exccode  (wb_exccode),
    .wb_badvaddr (wb_badvaddr)
  );

  // Bus slave: addr_ok after aok_dly waiting cycles, data_ok dok_dly cycles after acceptance.
  int          aok_dly = 0;
  int          dok_dly = 0;
  int          aok_cnt;
  int          dok_cnt;
  logic        pend;
  logic [31:0] slv_rdata = 32'h0;

  assign dbus.data_addr_ok = dbus.data_req && (aok_cnt >= aok_dly);
  assign dbus.data_data_ok = pend && (dok_cnt >= dok_dly);
  assign dbus.data_rdata   = slv_rdata;

  always @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      aok_cnt <= 0;
      dok_cnt <= 0;
      pend    <= 1'b0;
    end else begin
      if (dbus.data_req && !dbus.data_addr_ok) aok_cnt <= aok_cnt + 1;
      else                                     aok_cnt <= 0;
      if (dbus.data_req && dbus.data_addr_ok) begin
        pend    <= 1'b1;
        dok_cnt <= 0;
      end else if (dbus.data_data_ok) begin
        pend <= 1'b0;
      end else if (pend) begin
        dok_cnt <= dok_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [31:0] wd;
    logic        wreg;
    logic [4:0]  exc;
    logic [31:0] bad;
  } exp_t;
  exp_t sb[$];

  typedef struct packed {
    int          stall_n;
    int          req_n;
    logic        bus_changed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        wr;
    logic [31:0] wd;
    logic        wreg;
    logic [4:0]  exc;
    logic [31:0] bad;
    logic        hold_bad;
    logic        timeout;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                        input logic mreg, input logic wreg);
    mem_aluop   = op;
    mem_wd      = addr;
    mem_din     = din;
    mem_mreg    = mreg;
    mem_wreg    = wreg;
    mem_wa      = (op == 8'h00) ? 5'd0 : 5'd9;
    mem_exccode = EXC_NONE;
  endtask

  // Presents one instruction, follows it to DONE (or no stall), optionally holds DONE.
  task automatic drive_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] din,
                          input logic mreg, input logic wreg, input int hold, output obs_t o);
    o = '0;
    set_op(op, addr, din, mreg, wreg);
    for (int c = 0; c < 40; c++) begin
      @(negedge cpu_clk_50M);
      if (dbus.data_req) begin
        if (o.req_n == 0) begin
          o.addr  = dbus.data_addr;
          o.wdata = dbus.data_wdata;
          o.size  = dbus.data_size;
          o.wr    = dbus.data_wr;
        end else if (o.addr !== dbus.data_addr || o.wdata !== dbus.data_wdata ||
                     o.size !== dbus.data_size || o.wr !== dbus.data_wr) begin
          o.bus_changed = 1'b1;
        end
        o.req_n++;
      end
      if (!stallreq_mem) break;
      o.stall_n++;
      if (c == 39) o.timeout = 1'b1;
      @(posedge cpu_clk_50M); #1;
    end
    o.wd   = wb_wd;
    o.wreg = wb_wreg;
    o.exc  = wb_exccode;
    o.bad  = wb_badvaddr;
    if (hold > 0) begin
      stall_hold = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(posedge cpu_clk_50M); #1;
        @(negedge cpu_clk_50M);
        if (wb_wd !== o.wd || dbus.data_req !== 1'b0 || stallreq_mem !== 1'b0) o.hold_bad = 1'b1;
      end
      stall_hold = 1'b0;
    end
    @(posedge cpu_clk_50M); #1;
    set_op(8'h00, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cpu_rst = 1'b1;
    set_op(ALUOP_LW, 32'h1000_0004, 32'h0, 1'b1, 1'b1);
    @(negedge cpu_clk_50M);
    n_checks++; if (dbus.data_req !== 1'b0) $display("FAIL rst_req: got %b want 0", dbus.data_req); else n_pass++;
    n_checks++; if (stallreq_mem !== 1'b0) $display("FAIL rst_stall: got %b want 0", stallreq_mem); else n_pass++;
    n_checks++; if (dbus.data_addr !== 32'h0 || wb_wd !== 32'h0 || wb_wa !== 5'd0)
      $display("FAIL rst_data: addr %h wd %h wa %0d want 0", dbus.data_addr, wb_wd, wb_wa); else n_pass++;
    n_checks++; if (wb_exccode !== EXC_NONE) $display("FAIL rst_exc: got %h want %h", wb_exccode, EXC_NONE); else n_pass++;
    set_op(8'h00, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge cpu_clk_50M); #1;
    cpu_rst = 1'b0;
    @(posedge cpu_clk_50M); #1;
  endtask

  task automatic test_lw();
    obs_t o; exp_t e;
    aok_dly = 0; dok_dly = 0; slv_rdata = 32'hDEAD_BEEF;
    sb.push_back('{32'hDEAD_BEEF, 1'b1, EXC_NONE, 32'h0});
    drive_op(ALUOP_LW, 32'h1000_0004, 32'h0, 1'b1, 1'b1, 0, o);
    e = sb.pop_front();
    n_checks++; if (o.timeout || o.stall_n !== 2) $display("FAIL lw_stall: got %0d cycles (timeout %b) want 2", o.stall_n, o.timeout); else n_pass++;
    n_checks++; if (o.req_n !== 1 || o.addr !== 32'h1000_0004 || o.size !== SIZE_WORD || o.wr !== 1'b0)
      $display("FAIL lw_bus: req %0d addr %h size %0d wr %b want 1 10000004 2 0", o.req_n, o.addr, o.size, o.wr); else n_pass++;
    n_checks++; if (o.wd !== e.wd || o.wreg !== e.wreg) $display("FAIL lw_wb: got %h/%b want %h/%b", o.wd, o.wreg, e.wd, e.wreg); else n_pass++;
  endtask

  task automatic test_load_ext();
    obs_t o; exp_t e;
    logic [7:0]  ops [4];
    logic [31:0] adr [4];
    logic [31:0] want[4];
    ops[0] = ALUOP_LB;  adr[0] = 32'h2000_0003; want[0] = 32'hFFFF_FF80;
    ops[1] = ALUOP_LBU; adr[1] = 32'h2000_0003; want[1] = 32'h0000_0080;
    ops[2] = ALUOP_LHU; adr[2] = 32'h2000_0002; want[2] = 32'h0000_8011;
    ops[3] = ALUOP_LH;  adr[3] = 32'h2000_0002; want[3] = 32'hFFFF_8011;
    slv_rdata = 32'h8011_2233;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{want[i], 1'b1, EXC_NONE, 32'h0});
      drive_op(ops[i], adr[i], 32'h0, 1'b1, 1'b1, 0, o);
      e = sb.pop_front();
      n_checks++; if (o.timeout || o.wd !== e.wd)
        $display("FAIL ext_%0d: got %h want %h (stall %0d)", i, o.wd, e.wd, o.stall_n); else n_pass++;
    end
  endtask

  task automatic test_store_sh();
    obs_t o; exp_t e;
    aok_dly = 3;
    sb.push_back('{32'h3000_0002, 1'b0, EXC_NONE, 32'h0});
    drive_op(ALUOP_SH, 32'h3000_0002, 32'h1234_ABCD, 1'b0, 1'b0, 0, o);
    e = sb.pop_front();
    aok_dly = 0;
    n_checks++; if (o.req_n !== 4 || o.bus_changed) $display("FAIL sh_req: held %0d cycles changed %b want 4 0", o.req_n, o.bus_changed); else n_pass++;
    n_checks++; if (o.wdata !== 32'hABCD_ABCD || o.size !== SIZE_HALF || o.wr !== 1'b1)
      $display("FAIL sh_bus: wdata %h size %0d wr %b want abcdabcd 1 1", o.wdata, o.size, o.wr); else n_pass++;
    n_checks++; if (o.stall_n !== 5 || o.wd !== e.wd || o.wreg !== e.wreg)
      $display("FAIL sh_wb: stall %0d wd %h wreg %b want 5 %h %b", o.stall_n, o.wd, o.wreg, e.wd, e.wreg); else n_pass++;
  endtask

  task automatic test_store_lanes();
    obs_t o;
    logic [7:0]  ops [2];
    logic [31:0] adr [2];
    logic [31:0] din [2];
    logic [31:0] wdat[2];
    logic [1:0]  siz [2];
    ops[0] = ALUOP_SB; adr[0] = 32'h3000_0001; din[0] = 32'hAABB_CC77; wdat[0] = 32'h7777_7777; siz[0] = SIZE_BYTE;
    ops[1] = ALUOP_SW; adr[1] = 32'h3000_0004; din[1] = 32'hCAFE_F00D; wdat[1] = 32'hCAFE_F00D; siz[1] = SIZE_WORD;
    for (int i = 0; i < 2; i++) begin
      drive_op(ops[i], adr[i], din[i], 1'b0, 1'b0, 0, o);
      n_checks++; if (o.req_n !== 1 || o.wdata !== wdat[i] || o.size !== siz[i] || o.addr !== adr[i] || o.stall_n !== 2)
        $display("FAIL store_%0d: req %0d wdata %h size %0d addr %h stall %0d want 1 %h %0d %h 2",
                 i, o.req_n, o.wdata, o.size, o.addr, o.stall_n, wdat[i], siz[i], adr[i]); else n_pass++;
    end
  endtask

  task automatic test_misalign();
    obs_t o; exp_t e;
    logic [7:0]  ops[3];
    logic [31:0] adr[3];
    logic [4:0]  exc[3];
    ops[0] = ALUOP_LW; adr[0] = 32'h1000_0002; exc[0] = EXC_ADEL;
    ops[1] = ALUOP_SW; adr[1] = 32'h1000_0001; exc[1] = EXC_ADES;
    ops[2] = ALUOP_LH; adr[2] = 32'h1000_0003; exc[2] = EXC_ADEL;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{32'h0, 1'b0, exc[i], adr[i]});
      drive_op(ops[i], adr[i], 32'h5555_5555, ops[i] != ALUOP_SW, ops[i] != ALUOP_SW, 0, o);
      e = sb.pop_front();
      n_checks++; if (o.req_n !== 0 || o.stall_n !== 0) $display("FAIL mis_%0d_req: req %0d stall %0d want 0 0", i, o.req_n, o.stall_n); else n_pass++;
      n_checks++; if (o.exc !== e.exc || o.bad !== e.bad || o.wreg !== e.wreg)
        $display("FAIL mis_%0d_wb: exc %h bad %h wreg %b want %h %h %b", i, o.exc, o.bad, o.wreg, e.exc, e.bad, e.wreg); else n_pass++;
    end
  endtask

  task automatic test_passthrough();
    obs_t o; exp_t e;
    sb.push_back('{32'h0000_55AA, 1'b1, EXC_NONE, 32'h0});
    drive_op(8'h18, 32'h0000_55AA, 32'h0, 1'b0, 1'b1, 0, o);
    e = sb.pop_front();
    n_checks++; if (o.stall_n !== 0 || o.req_n !== 0 || o.wd !== e.wd || o.wreg !== e.wreg || o.exc !== e.exc)
      $display("FAIL pass: stall %0d req %0d wd %h wreg %b exc %h want 0 0 %h %b %h",
               o.stall_n, o.req_n, o.wd, o.wreg, o.exc, e.wd, e.wreg, e.exc); else n_pass++;
  endtask

  task automatic test_flush_wait();
    obs_t o; exp_t e;
    aok_dly = 0; dok_dly = 2; slv_rdata = 32'hBAD0_BAD0;
    set_op(ALUOP_LW, 32'h0000_0100, 32'h0, 1'b1, 1'b1);
    @(negedge cpu_clk_50M);
    n_checks++; if (dbus.data_req !== 1'b1) $display("FAIL flush_issue: req %b want 1", dbus.data_req); else n_pass++;
    @(posedge cpu_clk_50M); #1;
    flush = 1'b1;
    @(negedge cpu_clk_50M);
    n_checks++; if (wb_wreg !== 1'b0 || stallreq_mem !== 1'b1) $display("FAIL flush_wait: wreg %b stall %b want 0 1", wb_wreg, stallreq_mem); else n_pass++;
    @(posedge cpu_clk_50M); #1;
    flush = 1'b0;
    sb.push_back('{32'h1122_3344, 1'b1, EXC_NONE, 32'h0});
    set_op(ALUOP_LW, 32'h0000_0204, 32'h0, 1'b1, 1'b1);
    @(negedge cpu_clk_50M);
    n_checks++; if (dbus.data_req !== 1'b0 || stallreq_mem !== 1'b1) $display("FAIL drain_hold: req %b stall %b want 0 1", dbus.data_req, stallreq_mem); else n_pass++;
    @(posedge cpu_clk_50M); #1;
    @(negedge cpu_clk_50M);
    n_checks++; if (dbus.data_req !== 1'b0 || stallreq_mem !== 1'b1) $display("FAIL drain_last: req %b stall %b want 0 1", dbus.data_req, stallreq_mem); else n_pass++;
    @(posedge cpu_clk_50M); #1;
    slv_rdata = 32'h1122_3344;
    drive_op(ALUOP_LW, 32'h0000_0204, 32'h0, 1'b1, 1'b1, 0, o);
    e = sb.pop_front();
    dok_dly = 0;
    n_checks++; if (o.req_n !== 1 || o.stall_n !== 4) $display("FAIL after_drain: req %0d stall %0d want 1 4", o.req_n, o.stall_n); else n_pass++;
    n_checks++; if (o.wd !== e.wd || o.wreg !== e.wreg) $display("FAIL after_drain_wb: got %h/%b want %h/%b", o.wd, o.wreg, e.wd, e.wreg); else n_pass++;
  endtask

  task automatic test_done_hold();
    obs_t o; exp_t e;
    slv_rdata = 32'h1357_9BDF;
    sb.push_back('{32'h1357_9BDF, 1'b1, EXC_NONE, 32'h0});
    drive_op(ALUOP_LW, 32'h0000_0400, 32'h0, 1'b1, 1'b1, 3, o);
    e = sb.pop_front();
    n_checks++; if (o.wd !== e.wd || o.stall_n !== 2) $display("FAIL hold_wd: got %h stall %0d want %h 2", o.wd, o.stall_n, e.wd); else n_pass++;
    n_checks++; if (o.hold_bad !== 1'b0) $display("FAIL hold_stable: got %b want 0", o.hold_bad); else n_pass++;
  endtask

  task automatic test_reset_wait();
    obs_t o; exp_t e;
    dok_dly = 5; slv_rdata = 32'hFFFF_0000;
    set_op(ALUOP_LW, 32'h0000_0500, 32'h0, 1'b1, 1'b1);
    @(negedge cpu_clk_50M);
    @(posedge cpu_clk_50M); #1;
    cpu_rst = 1'b1;
    #1;
    n_checks++; if (stallreq_mem !== 1'b0 || dbus.data_req !== 1'b0 || dbus.data_addr !== 32'h0)
      $display("FAIL rstw_bus: stall %b req %b addr %h want 0 0 0", stallreq_mem, dbus.data_req, dbus.data_addr); else n_pass++;
    n_checks++; if (wb_wd !== 32'h0 || wb_wreg !== 1'b0 || wb_wa !== 5'd0 || wb_exccode !== EXC_NONE)
      $display("FAIL rstw_wb: wd %h wreg %b wa %0d exc %h want 0 0 0 %h", wb_wd, wb_wreg, wb_wa, wb_exccode, EXC_NONE); else n_pass++;
    set_op(8'h00, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge cpu_clk_50M); #1;
    cpu_rst = 1'b0; dok_dly = 0; slv_rdata = 32'h2468_ACE0;
    sb.push_back('{32'h2468_ACE0, 1'b1, EXC_NONE, 32'h0});
    drive_op(ALUOP_LW, 32'h0000_0600, 32'h0, 1'b1, 1'b1, 0, o);
    e = sb.pop_front();
    n_checks++; if (o.stall_n !== 2 || o.wd !== e.wd) $display("FAIL rstw_next: stall %0d wd %h want 2 %h", o.stall_n, o.wd, e.wd); else n_pass++;
  endtask

  initial begin
    flush = 1'b0;
    stall_hold = 1'b0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store_sh();
    test_store_lanes();
    test_misalign();
    test_passthrough();
    test_flush_wait();
    test_done_hold();
    test_reset_wait();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, %0d of %0d done", n_pass, n_checks);
    $fatal(1);
  end

endmodule
